// File: rtl/ifc_add_pkg.sv
// Shared encodings for the ifc_add initiator: data/cfg FSM states and cfg opcodes.
package ifc_add_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN    = 3'd1,
    DATA   = 3'd2,
    RESULT = 3'd3,
    DONE   = 3'd4
  } data_state_e;

  typedef enum logic [1:0] {
    CIDLE  = 2'd0,
    CISSUE = 2'd1,
    CRESP  = 2'd2
  } cfg_state_e;

  localparam logic CFG_OP_READ  = 1'b0;
  localparam logic CFG_OP_WRITE = 1'b1;

endpackage

// File: rtl/ifc_add_wdog.sv
// Wait-cycle watchdog: counts while enabled, expires in the TIMEOUT-th waiting cycle.
module ifc_add_wdog #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned TO_W    = 11
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam logic [TO_W-1:0] LIMIT = (TIMEOUT == 0) ? {TO_W{1'b0}} : TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] r_cnt;

  // consecutive cycles spent waiting on the current rdy
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt <= {TO_W{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {TO_W{1'b0}};
    end else if (i_en) begin
      r_cnt <= r_cnt + {{(TO_W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_expire = (TIMEOUT != 0) && i_en && (r_cnt == LIMIT);

endmodule

// File: rtl/ifc_add_master.sv
// Initiator for the ifc_add method interface: len/din/dout command sequencing with a
// per-call watchdog, plus an independent cfg register-access channel.
module ifc_add_master
  import ifc_add_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned TO_W    = 11
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [7:0]  req_len,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [7:0]  res_data,
  output logic        res_err,
  output logic        res_valid,
  input  logic        res_ready,
  input  logic [7:0]  creq_addr,
  input  logic [31:0] creq_wdata,
  input  logic        creq_write,
  input  logic        creq_valid,
  output logic        creq_ready,
  output logic [31:0] cresp_data,
  output logic        cresp_valid,
  input  logic        cresp_ready,
  output logic [7:0]  len_value,
  output logic        len_en,
  input  logic        len_rdy,
  output logic [7:0]  din_value,
  output logic        din_en,
  input  logic        din_rdy,
  output logic        dout_en,
  input  logic [7:0]  dout_value,
  input  logic        dout_rdy,
  output logic [7:0]  cfg_address,
  output logic [31:0] cfg_data_in,
  output logic        cfg_op,
  output logic        cfg_en,
  input  logic [31:0] cfg_data_out,
  input  logic        cfg_rdy,
  output logic        busy,
  output logic        err_sticky
);

  data_state_e r_state;
  cfg_state_e  r_cstate;
  logic [7:0]  r_cnt;

  logic w_len_fire;
  logic w_din_fire;
  logic w_dout_fire;
  logic w_wd_en;
  logic w_wd_clr;
  logic w_wd_expire;

  // Enables follow rdy combinationally so a call can only ever fire when the callee is ready.
  assign w_len_fire  = (r_state == LEN) && len_rdy;
  assign w_din_fire  = (r_state == DATA) && s_valid && din_rdy;
  assign w_dout_fire = (r_state == RESULT) && dout_rdy;

  assign len_en    = w_len_fire;
  assign din_en    = w_din_fire;
  assign s_ready   = w_din_fire;
  assign din_value = s_data;
  assign dout_en   = w_dout_fire;
  assign req_ready = (r_state == IDLE);
  assign res_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);

  // A starved stream (s_valid low) is not the callee's fault, so DATA only counts on din_rdy stalls.
  assign w_wd_en  = ((r_state == LEN) && !len_rdy) ||
                    ((r_state == DATA) && s_valid && !din_rdy) ||
                    ((r_state == RESULT) && !dout_rdy);
  assign w_wd_clr = !(r_state inside {LEN, DATA, RESULT}) ||
                    w_len_fire || w_din_fire || w_dout_fire || w_wd_expire;

  ifc_add_wdog #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_wdog (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .i_clr    (w_wd_clr),
    .i_en     (w_wd_en),
    .o_expire (w_wd_expire)
  );

  // data FSM: command accept, len call, byte stream, dout result, hold until consumed
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= IDLE;
      r_cnt      <= 8'd0;
      len_value  <= 8'd0;
      res_data   <= 8'd0;
      res_err    <= 1'b0;
      err_sticky <= 1'b0;
    end else if (w_wd_expire) begin
      r_state    <= DONE;
      res_data   <= 8'd0;
      res_err    <= 1'b1;
      err_sticky <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            if (req_len == 8'd0) begin
              r_state  <= DONE;
              res_data <= 8'd0;
              res_err  <= 1'b1;
            end else begin
              len_value <= req_len;
              r_cnt     <= req_len;
              r_state   <= LEN;
            end
          end
        end
        LEN: begin
          if (len_rdy) begin
            r_state <= DATA;
          end
        end
        DATA: begin
          if (w_din_fire) begin
            r_cnt <= r_cnt - 8'd1;
            if (r_cnt == 8'd1) begin
              r_state <= RESULT;
            end
          end
        end
        RESULT: begin
          if (dout_rdy) begin
            res_data <= dout_value;
            res_err  <= 1'b0;
            r_state  <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign creq_ready  = (r_cstate == CIDLE);
  assign cfg_en      = (r_cstate == CISSUE) && cfg_rdy;
  assign cresp_valid = (r_cstate == CRESP);

  // cfg FSM: latch request, issue when cfg_rdy, return captured data (writes included)
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cstate    <= CIDLE;
      cfg_address <= 8'd0;
      cfg_data_in <= 32'd0;
      cfg_op      <= CFG_OP_READ;
      cresp_data  <= 32'd0;
    end else begin
      case (r_cstate)
        CIDLE: begin
          if (creq_valid) begin
            cfg_address <= creq_addr;
            cfg_data_in <= creq_wdata;
            cfg_op      <= creq_write ? CFG_OP_WRITE : CFG_OP_READ;
            r_cstate    <= CISSUE;
          end
        end
        CISSUE: begin
          if (cfg_rdy) begin
            cresp_data <= cfg_data_out;
            r_cstate   <= CRESP;
          end
        end
        CRESP: begin
          if (cresp_ready) begin
            r_cstate <= CIDLE;
          end
        end
        default: r_cstate <= CIDLE;
      endcase
    end
  end

endmodule
